// File: rtl/rubik_pkg.sv
// rubik_pkg: shared types and HID keycode constants for the Rubik's cube move queue
package rubik_pkg;

    typedef enum logic [2:0] {
        U = 3'd0,
        D = 3'd1,
        L = 3'd2,
        R = 3'd3,
        F = 3'd4,
        B = 3'd5
    } face_t;

    typedef struct packed {
        face_t face;
        logic  prime;
    } move_cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        HELD
    } state_t;

    localparam logic [7:0] KC_U   = 8'h18;
    localparam logic [7:0] KC_D   = 8'h07;
    localparam logic [7:0] KC_L   = 8'h0F;
    localparam logic [7:0] KC_R   = 8'h15;
    localparam logic [7:0] KC_F   = 8'h09;
    localparam logic [7:0] KC_B   = 8'h05;
    localparam logic [7:0] KC_ESC = 8'h29;

endpackage

// File: rtl/move_cmd_fifo.sv
// move_cmd_fifo: show-ahead FIFO of rotation commands with flush
// Ports: clk, rst_n (async active-low), push/din, pop/dout (head, valid when !empty),
//        flush (empties the queue, wins over pop), fill_level, full, empty.
module move_cmd_fifo
    import rubik_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  move_cmd_t                din,
    input  logic                     pop,
    input  logic                     flush,
    output move_cmd_t                dout,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    move_cmd_t       mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = fill_level == FULL_LEVEL;
    assign empty   = fill_level == '0;
    assign dout    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    // a push into a full queue only fits when the head leaves on the same edge
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            fill_level <= fill_level + LW'(do_push) - LW'(do_pop);
        end
    end

endmodule

// File: rtl/keycode_move_queue.sv
// keycode_move_queue: debounces PIO keycodes, maps face keys to rotation commands, queues them
// Ports: Clk, Reset_n (async active-low), keycode (HID code, 0 = none), prime (CCW level),
//        cmd_ready/cmd_valid/cmd_face/cmd_prime (command handshake to the rotation engine),
//        fill_level (queued entries), overflow (sticky: press dropped while full).
module keycode_move_queue
    import rubik_pkg::*;
#(
    parameter int DEPTH         = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic [7:0]               keycode,
    input  logic                     prime,
    input  logic                     cmd_ready,
    output logic                     cmd_valid,
    output logic [2:0]               cmd_face,
    output logic                     cmd_prime,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic                     overflow
);
    localparam int CW = $clog2(STABLE_CYCLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

    state_t          state_q, state_d;
    logic [7:0]      kc_q, kc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            change;
    logic            is_face;
    logic            is_esc;
    logic [2:0]      face_idx;
    logic            push;
    logic            flush;
    logic            pop;
    logic            full;
    logic            empty;
    move_cmd_t       wr_cmd;
    move_cmd_t       head;

    assign change   = keycode != kc_q;
    assign is_esc   = kc_q == KC_ESC;
    assign is_face  = kc_q == KC_U || kc_q == KC_D || kc_q == KC_L ||
                      kc_q == KC_R || kc_q == KC_F || kc_q == KC_B;
    assign face_idx = kc_q == KC_D ? 3'd1 :
                      kc_q == KC_L ? 3'd2 :
                      kc_q == KC_R ? 3'd3 :
                      kc_q == KC_F ? 3'd4 :
                      kc_q == KC_B ? 3'd5 : 3'd0;
    assign wr_cmd   = '{face: face_t'(face_idx), prime: prime};

    // any change restarts qualification, even a return to an earlier code
    always_comb begin
        state_d = state_q;
        kc_d    = kc_q;
        cnt_d   = cnt_q;
        push    = 1'b0;
        flush   = 1'b0;
        if (change) begin
            kc_d    = keycode;
            cnt_d   = '0;
            state_d = keycode != 8'h00 ? ARMED : IDLE;
        end else if (state_q == ARMED) begin
            if (cnt_q == LAST) begin
                push    = is_face;
                flush   = is_esc;
                state_d = HELD;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= IDLE;
            kc_q     <= '0;
            cnt_q    <= '0;
            overflow <= 1'b0;
        end else begin
            state_q  <= state_d;
            kc_q     <= kc_d;
            cnt_q    <= cnt_d;
            overflow <= flush ? 1'b0 : (overflow || (push && full && !pop));
        end
    end

    assign pop       = cmd_valid && cmd_ready;
    assign cmd_valid = !empty;
    assign cmd_face  = cmd_valid ? head.face : 3'd0;
    assign cmd_prime = cmd_valid && head.prime;

    move_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (Clk),
        .rst_n      (Reset_n),
        .push       (push),
        .din        (wr_cmd),
        .pop        (pop),
        .flush      (flush),
        .dout       (head),
        .fill_level (fill_level),
        .full       (full),
        .empty      (empty)
    );

endmodule

// File: tb/tb_keycode_move_queue.sv
// tb_keycode_move_queue: table-driven and scoreboard bench for keycode_move_queue
module tb_keycode_move_queue;
    localparam int DEPTH = 8;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic [7:0] keycode = 8'h00;
    logic       prime = 1'b0;
    logic       cmd_ready = 1'b0;
    logic       cmd_valid;
    logic [2:0] cmd_face;
    logic       cmd_prime;
    logic [3:0] fill_level;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    int pops = 0;
    bit mon_en = 1'b1;

    typedef struct {
        int face;
        int prime;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [7:0] kc;
        logic       pr;
        int         hold;
        bit         push;
        int         face;
        int         fill;
    } vec_t;
    vec_t vecs[7];

    keycode_move_queue #(.DEPTH(DEPTH), .STABLE_CYCLES(4)) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .keycode    (keycode),
        .prime      (prime),
        .cmd_ready  (cmd_ready),
        .cmd_valid  (cmd_valid),
        .cmd_face   (cmd_face),
        .cmd_prime  (cmd_prime),
        .fill_level (fill_level),
        .overflow   (overflow)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic expect_cmd(input int face, input int pr);
        exp_t e;
        e.face = face;
        e.prime = pr;
        exp_q.push_back(e);
    endtask

    // every accepted pop is compared against the oldest expected command
    always @(negedge Clk) begin
        exp_t e;
        if (Reset_n && mon_en && cmd_valid && cmd_ready) begin
            pops++;
            if (exp_q.size() == 0) check("pop_unexpected", 1, 0);
            else begin
                e = exp_q.pop_front();
                check("pop_face", int'(cmd_face), e.face);
                check("pop_prime", int'(cmd_prime), e.prime);
            end
        end
    end

    // code presented on `hold` consecutive edges, then 0x00 for two edges
    task automatic press(input logic [7:0] kc, input logic pr, input int hold);
        @(posedge Clk);
        #1 keycode = kc;
        prime = pr;
        repeat (hold) @(posedge Clk);
        #1 keycode = 8'h00;
        repeat (2) @(posedge Clk);
    endtask

    task automatic drain(input int n);
        pops = 0;
        @(posedge Clk);
        #1 cmd_ready = 1'b1;
        for (int i = 0; i < 4 * DEPTH && cmd_valid; i++) begin
            @(posedge Clk);
            #1;
        end
        cmd_ready = 1'b0;
        @(negedge Clk);
        check("drain_valid", int'(cmd_valid), 0);
        check("drain_fill", int'(fill_level), 0);
        check("drain_pops", pops, n);
        check("drain_left", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{8'h18, 1'b0, 6, 1'b1, 0, 1};
        vecs[1] = '{8'h07, 1'b1, 5, 1'b1, 1, 2};
        vecs[2] = '{8'h18, 1'b0, 3, 1'b0, 0, 2};
        vecs[3] = '{8'h15, 1'b1, 4, 1'b0, 0, 2};
        vecs[4] = '{8'h09, 1'b1, 5, 1'b1, 4, 3};
        vecs[5] = '{8'h05, 1'b0, 8, 1'b1, 5, 4};
        vecs[6] = '{8'h04, 1'b0, 6, 1'b0, 0, 4};

        #12;
        check("rst_valid", int'(cmd_valid), 0);
        check("rst_face", int'(cmd_face), 0);
        check("rst_prime", int'(cmd_prime), 0);
        check("rst_fill", int'(fill_level), 0);
        check("rst_overflow", int'(overflow), 0);
        @(posedge Clk);
        #1 Reset_n = 1'b1;

        // press latency: push lands on E0+4
        @(posedge Clk);
        #1 keycode = 8'h15;
        prime = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge Clk);
            @(negedge Clk);
            check("lat_fill", int'(fill_level), i >= 4 ? 1 : 0);
        end
        check("lat_valid", int'(cmd_valid), 1);
        check("lat_face", int'(cmd_face), 3);
        check("lat_prime", int'(cmd_prime), 0);
        expect_cmd(3, 0);
        @(posedge Clk);
        #1 keycode = 8'h00;
        repeat (2) @(posedge Clk);
        drain(1);

        for (int v = 0; v < 7; v++) begin
            press(vecs[v].kc, vecs[v].pr, vecs[v].hold);
            if (vecs[v].push) expect_cmd(vecs[v].face, int'(vecs[v].pr));
            @(negedge Clk);
            check("vec_fill", int'(fill_level), vecs[v].fill);
            check("vec_overflow", int'(overflow), 0);
            check("vec_head_stable", int'(cmd_face), 0);
        end

        // face key straight to another face key with no release in between
        @(posedge Clk);
        #1 keycode = 8'h0F;
        prime = 1'b0;
        repeat (6) @(posedge Clk);
        #1 keycode = 8'h15;
        prime = 1'b1;
        repeat (6) @(posedge Clk);
        #1 keycode = 8'h00;
        repeat (2) @(posedge Clk);
        expect_cmd(2, 0);
        expect_cmd(3, 1);
        @(negedge Clk);
        check("direct_fill", int'(fill_level), 6);
        drain(6);

        // nine presses into an eight-entry queue
        for (int i = 0; i < 9; i++) begin
            press(8'h09, logic'(i[0]), 5);
            if (i < 8) expect_cmd(4, i % 2);
        end
        @(negedge Clk);
        check("ovf_fill", int'(fill_level), 8);
        check("ovf_flag", int'(overflow), 1);
        drain(8);
        check("ovf_sticky", int'(overflow), 1);

        press(8'h29, 1'b0, 5);
        @(negedge Clk);
        check("esc_ovf_clear", int'(overflow), 0);

        // full queue, push on the same edge as a pop
        for (int i = 0; i < 8; i++) begin
            press(8'h18 - 8'(i % 2) * 8'h11, 1'b0, 5);
            expect_cmd((i % 2) ? 1 : 0, 0);
        end
        @(negedge Clk);
        check("full_fill", int'(fill_level), 8);
        check("full_ovf", int'(overflow), 0);
        @(posedge Clk);
        #1 keycode = 8'h05;
        prime = 1'b1;
        repeat (4) @(posedge Clk);
        #1 cmd_ready = 1'b1;
        @(posedge Clk);
        #1 cmd_ready = 1'b0;
        keycode = 8'h00;
        expect_cmd(5, 1);
        @(negedge Clk);
        check("pushpop_fill", int'(fill_level), 8);
        check("pushpop_ovf", int'(overflow), 0);
        press(8'h18, 1'b0, 5);
        @(negedge Clk);
        check("drop_fill", int'(fill_level), 8);
        check("drop_ovf", int'(overflow), 1);
        drain(8);

        // flush with a pop requested on the flush edge
        press(8'h18, 1'b0, 5);
        press(8'h07, 1'b1, 5);
        press(8'h0F, 1'b0, 5);
        @(negedge Clk);
        check("pre_flush_fill", int'(fill_level), 3);
        check("pre_flush_ovf", int'(overflow), 1);
        @(posedge Clk);
        #1 keycode = 8'h29;
        repeat (4) @(posedge Clk);
        #1 mon_en = 1'b0;
        cmd_ready = 1'b1;
        @(posedge Clk);
        #1 cmd_ready = 1'b0;
        mon_en = 1'b1;
        keycode = 8'h00;
        exp_q.delete();
        @(negedge Clk);
        check("flush_fill", int'(fill_level), 0);
        check("flush_ovf", int'(overflow), 0);
        check("flush_valid", int'(cmd_valid), 0);

        // asynchronous reset while ARMED with two entries queued
        press(8'h18, 1'b0, 5);
        press(8'h07, 1'b1, 5);
        @(negedge Clk);
        check("prereset_fill", int'(fill_level), 2);
        @(posedge Clk);
        #1 keycode = 8'h09;
        prime = 1'b0;
        repeat (2) @(posedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        check("areset_valid", int'(cmd_valid), 0);
        check("areset_face", int'(cmd_face), 0);
        check("areset_prime", int'(cmd_prime), 0);
        check("areset_fill", int'(fill_level), 0);
        check("areset_ovf", int'(overflow), 0);
        exp_q.delete();
        @(posedge Clk);
        #1 Reset_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(posedge Clk);
            @(negedge Clk);
            check("post_reset_fill", int'(fill_level), i >= 4 ? 1 : 0);
        end
        check("post_reset_face", int'(cmd_face), 4);
        check("post_reset_prime", int'(cmd_prime), 0);
        expect_cmd(4, 0);
        @(posedge Clk);
        #1 keycode = 8'h00;
        repeat (2) @(posedge Clk);
        drain(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/keycode_move_queue.md
# keycode_move_queue

Hardware consumer of the 8-bit USB keyboard keycode that the NIOS II software writes through the `keycode` PIO. It qualifies each key press and translates Rubik's face keys into rotation commands. Commands are held in a small FIFO and released to the cube rotation engine in `color_mapper` through a valid/ready handshake. Runs on `MAX10_CLK1_50`, the same clock as the PIO, so no synchronizer is needed.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `STABLE_CYCLES`, 4: cycles a new keycode must hold before it is accepted; ≥1.
- `Clk` in 1: 50 MHz system clock.
- `Reset_n` in 1: asynchronous, active-low reset.
- `keycode` in 8: HID usage code from the PIO; 0x00 means no key.
- `prime` in 1: level; when high, the command is counter-clockwise. Sampled on the push edge.
- `cmd_ready` in 1: rotation engine accepts the head command.
- `cmd_valid` out 1: FIFO non-empty.
- `cmd_face` out 3: face of the head entry; 0 when `!cmd_valid`.
- `cmd_prime` out 1: direction of the head entry; 0 when `!cmd_valid`.
- `fill_level` out $clog2(DEPTH)+1: number of valid entries.
- `overflow` out 1: sticky; a mapped press arrived while the FIFO was full.

## Operation
- Key map: U=0x18, D=0x07, L=0x0F, R=0x15, F=0x09, B=0x05 map to faces 0–5. ESC=0x29 is flush. All other codes are unmapped.
- Register `kc_q` holds the last sampled keycode. `change` is `keycode != kc_q`.
- On any edge with `change` asserted, in any state:
  - `kc_q` ← `keycode` and `cnt` ← 0.
  - Next state is ARMED if `keycode` ≠ 0, otherwise IDLE.
- FSM states: IDLE, ARMED, HELD.
  - IDLE: no key present; wait for `change`.
  - ARMED: while there is no change, increment `cnt`. When `cnt == STABLE_CYCLES-1` with no change: act on `kc_q`, then go to HELD.
    - Face key: push {face, `prime`}.
    - ESC: flush.
    - Unmapped: no action.
  - HELD: exactly one action per press; no auto-repeat. Leave only on `change`.
- Pop: on an edge with `cmd_valid && cmd_ready`.
- Full with simultaneous push and pop: both occur, `fill_level` is unchanged, and `overflow` is not set.
- Push while full and no pop: the entry is dropped and `overflow` ← 1.
- Flush: `fill_level` ← 0 and `overflow` ← 0. A pop on the same edge is ignored.
- Pointers wrap modulo DEPTH.

## Timing
- Reset values: state IDLE, `kc_q`=0, `cnt`=0. All outputs are 0.
- Reset asserted mid-operation clears all FIFO contents immediately (asynchronously).
- Press latency: `keycode` changes before edge E0.
  - With an empty FIFO, the push edge is E0+STABLE_CYCLES.
  - `cmd_valid`, `cmd_face` and `cmd_prime` are valid after that edge, without an extra read cycle.
- Pop latency: the new head, or `cmd_valid`=0, is visible after the pop edge.
- A glitch shorter than STABLE_CYCLES produces no push. Returning to the previous code still counts as a change.
- A direct change from one face key to another, with no 0x00 between them, produces a second push after STABLE_CYCLES.
- `cmd_face` and `cmd_prime` must stay stable while `cmd_valid && !cmd_ready`.

## Structure
- Package `rubik_pkg`:
  - `face_t` enum: U, D, L, R, F, B = 0–5.
  - `move_cmd_t` struct: {face_t face; logic prime}.
  - `localparam` HID constants: `KC_U`, `KC_D`, `KC_L`, `KC_R`, `KC_F`, `KC_B`, `KC_ESC`.
- One sub-module, `move_cmd_fifo`:
  - Parameterized by DEPTH.
  - Storage of type `move_cmd_t`, show-ahead.
  - Ports: push, pop, flush, `fill_level`, full, empty.
- The FSM and key map live in the top module.

## Test plan
- Keycode 0x15 held for 10 cycles, `prime`=0, `cmd_ready`=0 → one push at E0+4. Head is face 3 (R), `cmd_prime`=0, `fill_level`=1; no further push while held.
- Keycode 0x18 for 3 cycles, then 0x00 → no push; `fill_level` stays 0.
- Nine distinct presses (alternating 0x09/0x00, each held ≥5 cycles), `cmd_ready`=0 → `fill_level`=8 and `overflow`=1. Then drain with `cmd_ready`=1 → 8 commands in press order, `cmd_valid` falls after the 8th pop.
- FIFO full, then a press pushes on the same edge as a pop → `fill_level` stays 8 and `overflow` stays 0.
- 3 entries queued, then ESC (0x29) held 5 cycles with `cmd_ready`=1 on the flush edge → `fill_level`=0, `overflow`=0, `cmd_valid`=0, and no pop is counted.
- `Reset_n` pulsed low while ARMED with 2 entries queued → all outputs 0 immediately, state IDLE. A key still held after reset release is accepted as a new press at E0+4.
